alu_exec_ctrl: RTL and testbench
================================

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be 8, 16, 32 or 64.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount bits taken from opb[SHW-1:0].
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 valid_in  input  1  request present.
REQ-006 ready_out  output  1  block accepts a request this cycle.
REQ-007 aluop  input  2  00 load/store address, 01 branch compare, 10 R-type, 11 reserved.
REQ-008 instin  input  32  instruction; uses bits [31:25], [14:12].
REQ-009 opa, opb  input  XLEN each  source operands.
REQ-010 valid_out  output  1  result valid.
REQ-011 ready_in  input  1  consumer accepts result.
REQ-012 result  output  XLEN  registered result.
REQ-013 outsel  output  4  registered operation code of the accepted request.
REQ-014 illegal  output  1  accepted request had an undecodable encoding.

Function
REQ-015 Accept SHALL occur when valid_in && ready_out; operands, aluop and instin are captured at that edge only.
REQ-016 Decode: aluop 00 -> ADD; aluop 01 -> instin[13]=0 SLT, 1 SLTU; aluop 11 -> illegal.
REQ-017 aluop 10, instin[31:25]=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
REQ-018 aluop 10, instin[31:25]=0100000: funct3 000 SUB, 101 SRA; other funct3 illegal.
REQ-019 aluop 10, instin[31:25]=0000001: funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-020 Any other instin[31:25] with aluop 10 SHALL be illegal.
REQ-021 outsel codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLTU 1000, SLL 1001, SRL 1010, SRA 1011, XOR 1100, MUL-class 0011, DIV-class 0100, illegal 1111.
REQ-022 Illegal request SHALL complete as a single-cycle op with result 0 and illegal=1.
REQ-023 All arithmetic modulo 2^XLEN; SLT/SLTU produce 1 or 0 zero-extended; shifts use opb[SHW-1:0] only.
REQ-024 States IDLE, MUL, DIV, DONE.
REQ-025 IDLE: accept of single-cycle op -> DONE with result loaded; accept of MUL-class -> MUL; DIV-class -> DIV.
REQ-026 MUL: radix-2 shift-add over 2*XLEN-bit product, exactly XLEN iterations, then DONE; MUL returns low XLEN bits, others high XLEN bits with rs1/rs2 signedness per RISC-V.
REQ-027 DIV: restoring radix-2 on magnitudes, exactly XLEN iterations, sign correction in final iteration, then DONE.
REQ-028 Divide by zero: quotient all-ones, remainder = opa; SHALL go IDLE->DONE in one cycle.
REQ-029 Signed overflow (opa = -2^(XLEN-1), opb = -1): DIV returns opa, REM returns 0; one cycle.
REQ-030 Latency accept-to-valid_out: 1 cycle single-cycle ops, XLEN+1 cycles MUL/DIV.
REQ-031 DONE: valid_out=1; result, outsel, illegal stable until valid_out && ready_in.
REQ-032 ready_out = (state==IDLE) || (state==DONE && ready_in); back-to-back accept on release edge SHALL be supported.
REQ-033 In MUL/DIV, ready_out=0 and valid_in is ignored.
REQ-034 DONE with ready_in=1 and no new accept -> IDLE, valid_out=0.

Reset
REQ-035 rst_n low SHALL immediately force state IDLE, valid_out 0, result 0, outsel 0000, illegal 0, iteration counter 0, independent of clk.
REQ-036 Reset during MUL/DIV SHALL abandon the operation; no valid_out for it after release.
REQ-037 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-038 XLEN=32, aluop 10, instin[31:25]=0100000 funct3 000, opa=5, opb=7 -> next cycle valid_out=1, result 0xFFFFFFFE, outsel 0110.
REQ-039 MULH opa=0x80000000, opb=0x80000000 -> valid_out exactly 33 cycles after accept, result 0x40000000, outsel 0011.
REQ-040 DIV opa=0x80000000, opb=0xFFFFFFFF -> result 0x80000000 after 1 cycle; REMU opa=9, opb=0 -> result 9 after 1 cycle.
REQ-041 ready_in held 0 for 5 cycles in DONE -> result/valid_out stable, ready_out=0; then ready_in=1 with new valid_in ADD 1+1 -> accepted same edge, result 2 next cycle.
REQ-042 rst_n pulsed low at cycle 10 of DIVU -> outputs zero asynchronously, no valid_out after release; aluop 11 request -> illegal=1, result 0, outsel 1111.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// ALU execute controller: decodes aluop/instin, completes simple ALU ops in one
// cycle and sequences an iterative shift-add multiplier and restoring divider.
module alu_exec_ctrl #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [1:0]      aluop,
  input  logic [31:0]     instin,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [XLEN-1:0] result,
  output logic [3:0]      outsel,
  output logic            illegal
);

  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_MUL  = 4'b0011;
  localparam logic [3:0] SEL_DIV  = 4'b0100;
  localparam logic [3:0] SEL_SUB  = 4'b0110;
  localparam logic [3:0] SEL_SLT  = 4'b0111;
  localparam logic [3:0] SEL_SLTU = 4'b1000;
  localparam logic [3:0] SEL_SLL  = 4'b1001;
  localparam logic [3:0] SEL_SRL  = 4'b1010;
  localparam logic [3:0] SEL_SRA  = 4'b1011;
  localparam logic [3:0] SEL_XOR  = 4'b1100;
  localparam logic [3:0] SEL_ILL  = 4'b1111;

  localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);
  localparam logic [SHW-1:0]  CNT_ZERO = {SHW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CL_ALU = 2'd0,
    CL_MUL = 2'd1,
    CL_DIV = 2'd2
  } cls_t;

  state_t            state_r, state_nx_s, dispatch_s;
  cls_t              cls_s;
  logic [3:0]        sel_s;
  logic              ill_s, accept_s, last_s;
  logic [1:0]        fn_s;
  logic              sgn_a_s, sgn_b_s, neg_a_s, neg_b_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s, alu_s;
  logic              div_zero_s, div_ovf_s, div_fast_s;
  logic [XLEN-1:0]   div_fast_res_s;
  logic [SHW-1:0]    sh_s;

  // Iteration state; acc_r holds {hi, multiplier} for MUL and {remainder, quotient} for DIV.
  logic [2*XLEN-1:0] acc_r;
  logic [XLEN-1:0]   opd_r;
  logic [SHW-1:0]    cnt_r;
  logic [1:0]        fn_r;
  logic              neg_r, rneg_r;
  logic [XLEN-1:0]   result_r;
  logic [3:0]        outsel_r;
  logic              illegal_r, valid_r;

  logic [XLEN:0]     mul_sum_s;
  logic [2*XLEN-1:0] mul_nx_s, mul_sgn_s;
  logic [XLEN-1:0]   mul_res_s;
  logic [XLEN:0]     div_sh_s, div_diff_s;
  logic [XLEN-1:0]   div_rem_s, div_quo_s, div_qfix_s, div_rfix_s, div_res_s;
  logic [2*XLEN-1:0] div_nx_s;
  logic              unused_s;

  assign unused_s   = ^{instin[24:15], instin[11:0]};
  assign fn_s       = instin[13:12];
  assign sh_s       = opb[SHW-1:0];
  assign ill_s      = (sel_s == SEL_ILL);
  assign ready_out  = (state_r == ST_IDLE) || ((state_r == ST_DONE) && ready_in);
  assign accept_s   = valid_in && ready_out;
  assign last_s     = (cnt_r == CNT_ZERO);
  assign valid_out  = valid_r;
  assign result     = result_r;
  assign outsel     = outsel_r;
  assign illegal    = illegal_r;

  // Instruction decode into operation code and execution class.
  always_comb begin
    sel_s = SEL_ILL;
    cls_s = CL_ALU;
    case (aluop)
      2'b00: sel_s = SEL_ADD;
      2'b01: begin
        if (instin[13]) sel_s = SEL_SLTU;
        else            sel_s = SEL_SLT;
      end
      2'b10: begin
        case (instin[31:25])
          7'b0000000: begin
            case (instin[14:12])
              3'b000:  sel_s = SEL_ADD;
              3'b001:  sel_s = SEL_SLL;
              3'b010:  sel_s = SEL_SLT;
              3'b011:  sel_s = SEL_SLTU;
              3'b100:  sel_s = SEL_XOR;
              3'b101:  sel_s = SEL_SRL;
              3'b110:  sel_s = SEL_OR;
              default: sel_s = SEL_AND;
            endcase
          end
          7'b0100000: begin
            case (instin[14:12])
              3'b000:  sel_s = SEL_SUB;
              3'b101:  sel_s = SEL_SRA;
              default: sel_s = SEL_ILL;
            endcase
          end
          7'b0000001: begin
            if (instin[14]) begin
              sel_s = SEL_DIV;
              cls_s = CL_DIV;
            end else begin
              sel_s = SEL_MUL;
              cls_s = CL_MUL;
            end
          end
          default: sel_s = SEL_ILL;
        endcase
      end
      default: sel_s = SEL_ILL;
    endcase
  end

  // Operand signedness: MULH signs both, MULHSU only rs1; DIV/REM sign both.
  always_comb begin
    sgn_a_s = 1'b0;
    sgn_b_s = 1'b0;
    if (cls_s == CL_MUL) begin
      sgn_a_s = (fn_s == 2'b01) || (fn_s == 2'b10);
      sgn_b_s = (fn_s == 2'b01);
    end else if (cls_s == CL_DIV) begin
      sgn_a_s = ~fn_s[0];
      sgn_b_s = ~fn_s[0];
    end else begin
      sgn_a_s = 1'b0;
      sgn_b_s = 1'b0;
    end
  end

  assign neg_a_s    = sgn_a_s & opa[XLEN-1];
  assign neg_b_s    = sgn_b_s & opb[XLEN-1];
  assign mag_a_s    = neg_a_s ? -opa : opa;
  assign mag_b_s    = neg_b_s ? -opb : opb;
  assign div_zero_s = (opb == ZERO);
  assign div_ovf_s  = sgn_a_s && (opa == SMIN) && (opb == ONES);
  assign div_fast_s = (cls_s == CL_DIV) && (div_zero_s || div_ovf_s);

  // Divide-by-zero and signed-overflow results, which bypass the iterative divider.
  always_comb begin
    div_fast_res_s = ZERO;
    if (div_zero_s) begin
      if (fn_s[1]) div_fast_res_s = opa;
      else         div_fast_res_s = ONES;
    end else begin
      if (fn_s[1]) div_fast_res_s = ZERO;
      else         div_fast_res_s = opa;
    end
  end

  // Single-cycle ALU; illegal encodings fall through to zero.
  always_comb begin
    alu_s = ZERO;
    case (sel_s)
      SEL_AND:  alu_s = opa & opb;
      SEL_OR:   alu_s = opa | opb;
      SEL_ADD:  alu_s = opa + opb;
      SEL_SUB:  alu_s = opa - opb;
      SEL_SLT:  alu_s = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
      SEL_SLTU: alu_s = {{(XLEN-1){1'b0}}, (opa < opb)};
      SEL_SLL:  alu_s = opa << sh_s;
      SEL_SRL:  alu_s = opa >> sh_s;
      SEL_SRA:  alu_s = $signed(opa) >>> sh_s;
      SEL_XOR:  alu_s = opa ^ opb;
      default:  alu_s = ZERO;
    endcase
  end

  assign mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + ({1'b0, opd_r} & {(XLEN+1){acc_r[0]}});
  assign mul_nx_s   = {mul_sum_s, acc_r[XLEN-1:1]};
  assign mul_sgn_s  = neg_r ? -mul_nx_s : mul_nx_s;
  assign mul_res_s  = (fn_r == 2'b00) ? mul_sgn_s[XLEN-1:0] : mul_sgn_s[2*XLEN-1:XLEN];

  assign div_sh_s   = acc_r[2*XLEN-1:XLEN-1];
  assign div_diff_s = div_sh_s - {1'b0, opd_r};
  assign div_rem_s  = div_diff_s[XLEN] ? div_sh_s[XLEN-1:0] : div_diff_s[XLEN-1:0];
  assign div_quo_s  = {acc_r[XLEN-2:0], ~div_diff_s[XLEN]};
  assign div_nx_s   = {div_rem_s, div_quo_s};
  assign div_qfix_s = neg_r ? -div_quo_s : div_quo_s;
  assign div_rfix_s = rneg_r ? -div_rem_s : div_rem_s;
  assign div_res_s  = fn_r[1] ? div_rfix_s : div_qfix_s;

  // Where a newly accepted request goes.
  always_comb begin
    dispatch_s = ST_DONE;
    if (cls_s == CL_MUL)                    dispatch_s = ST_MUL;
    else if ((cls_s == CL_DIV) && !div_fast_s) dispatch_s = ST_DIV;
    else                                    dispatch_s = ST_DONE;
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = dispatch_s;
        else          state_nx_s = ST_IDLE;
      end
      ST_MUL, ST_DIV: begin
        if (last_s) state_nx_s = ST_DONE;
        else        state_nx_s = state_r;
      end
      ST_DONE: begin
        if (accept_s)      state_nx_s = dispatch_s;
        else if (ready_in) state_nx_s = ST_IDLE;
        else               state_nx_s = ST_DONE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // Datapath: capture at accept, iterate in MUL/DIV, load result on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= {(2*XLEN){1'b0}};
      opd_r     <= ZERO;
      cnt_r     <= CNT_ZERO;
      fn_r      <= 2'b00;
      neg_r     <= 1'b0;
      rneg_r    <= 1'b0;
      result_r  <= ZERO;
      outsel_r  <= 4'b0000;
      illegal_r <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      valid_r <= (state_nx_s == ST_DONE);
      if (accept_s) begin
        outsel_r  <= sel_s;
        illegal_r <= ill_s;
        fn_r      <= fn_s;
        neg_r     <= neg_a_s ^ neg_b_s;
        rneg_r    <= neg_a_s;
        cnt_r     <= CNT_LAST;
        if (cls_s == CL_MUL) begin
          acc_r <= {ZERO, mag_b_s};
          opd_r <= mag_a_s;
        end else if (cls_s == CL_DIV) begin
          acc_r <= {ZERO, mag_a_s};
          opd_r <= mag_b_s;
          if (div_fast_s) result_r <= div_fast_res_s;
        end else begin
          result_r <= alu_s;
        end
      end else if (state_r == ST_MUL) begin
        acc_r <= mul_nx_s;
        if (last_s) result_r <= mul_res_s;
        else        cnt_r    <= cnt_r - SHW'(1);
      end else if (state_r == ST_DIV) begin
        acc_r <= div_nx_s;
        if (last_s) result_r <= div_res_s;
        else        cnt_r    <= cnt_r - SHW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl (XLEN=32): expectations come from a
// behavioural reference model and are checked at the result handshake.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b1;
  logic [1:0]  aluop = 2'b00;
  logic [31:0] instin = 32'h0;
  logic [31:0] opa = 32'h0;
  logic [31:0] opb = 32'h0;
  logic        ready_out, valid_out, illegal;
  logic [31:0] result;
  logic [3:0]  outsel;

  alu_exec_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .aluop(aluop), .instin(instin), .opa(opa), .opb(opb),
    .valid_out(valid_out), .ready_in(ready_in), .result(result),
    .outsel(outsel), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  sel;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t pend_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rinst(input logic [6:0] f7, input logic [2:0] f3);
    rinst = {f7, 10'h2A5, f3, 12'hABC};
  endfunction

  // Reference model of the decoded operation.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] inst,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  sh;
    logic [63:0] ea, eb, p;
    logic [31:0] q, r;
    f7 = inst[31:25]; f3 = inst[14:12]; sh = b[4:0];
    e.res = 32'h0; e.sel = 4'b1111; e.ill = 1'b1; e.lat = 1; e.acc = 0;
    if (op == 2'b00) begin
      e.res = a + b; e.sel = 4'b0010; e.ill = 1'b0;
    end else if (op == 2'b01) begin
      e.ill = 1'b0;
      if (inst[13]) begin e.sel = 4'b1000; e.res = {31'h0, a < b}; end
      else begin e.sel = 4'b0111; e.res = {31'h0, $signed(a) < $signed(b)}; end
    end else if (op == 2'b10 && f7 == 7'h00) begin
      e.ill = 1'b0;
      case (f3)
        3'd0: begin e.sel = 4'b0010; e.res = a + b; end
        3'd1: begin e.sel = 4'b1001; e.res = a << sh; end
        3'd2: begin e.sel = 4'b0111; e.res = {31'h0, $signed(a) < $signed(b)}; end
        3'd3: begin e.sel = 4'b1000; e.res = {31'h0, a < b}; end
        3'd4: begin e.sel = 4'b1100; e.res = a ^ b; end
        3'd5: begin e.sel = 4'b1010; e.res = a >> sh; end
        3'd6: begin e.sel = 4'b0001; e.res = a | b; end
        default: begin e.sel = 4'b0000; e.res = a & b; end
      endcase
    end else if (op == 2'b10 && f7 == 7'h20 && f3 == 3'd0) begin
      e.ill = 1'b0; e.sel = 4'b0110; e.res = a - b;
    end else if (op == 2'b10 && f7 == 7'h20 && f3 == 3'd5) begin
      e.ill = 1'b0; e.sel = 4'b1011; e.res = $signed(a) >>> sh;
    end else if (op == 2'b10 && f7 == 7'h01 && !f3[2]) begin
      e.ill = 1'b0; e.sel = 4'b0011; e.lat = 33;
      ea = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'h0, a};
      eb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
      p = ea * eb;
      e.res = (f3 == 3'd0) ? p[31:0] : p[63:32];
    end else if (op == 2'b10 && f7 == 7'h01) begin
      e.ill = 1'b0; e.sel = 4'b0100; e.lat = 33;
      if (b == 32'h0) begin
        q = 32'hFFFF_FFFF; r = a; e.lat = 1;
      end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a; r = 32'h0; e.lat = 1;
      end else if (!f3[0]) begin
        q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
      end else begin
        q = a / b; r = a % b;
      end
      e.res = f3[1] ? r : q;
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push at accept, check latency on first sight, compare at handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        seen = 1'b0;
      end else begin
        if (valid_out) begin
          if (sb_q.size() == 0) begin
            chk("spurious_valid", valid_out, 1'b0);
          end else begin
            if (!seen) begin
              chk("latency", cyc - sb_q[0].acc + 1, sb_q[0].lat);
              seen = 1'b1;
            end
            if (ready_in) begin
              e = sb_q.pop_front();
              seen = 1'b0;
              chk("result", result, e.res);
              chk("outsel", outsel, e.sel);
              chk("illegal", illegal, e.ill);
            end
          end
        end
        if (valid_in && ready_out) begin
          e = pend_e;
          e.acc = cyc + 1;
          sb_q.push_back(e);
        end
      end
    end
  end

  // Called just after a rising edge; returns after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [31:0] inst,
                      input logic [31:0] a, input logic [31:0] b, output int waits);
    bit acc;
    pend_e = model(op, inst, a, b);
    aluop = op; instin = inst; opa = a; opb = b; valid_in = 1'b1;
    waits = 0;
    acc = 1'b0;
    while (!acc && waits <= 200) begin
      @(negedge clk); acc = ready_out;
      @(posedge clk); #1;
      if (!acc) waits++;
    end
    if (!acc) chk("accept_timeout", waits, 0);
    valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb_q.size() != 0 || valid_out) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_q", sb_q.size(), 0);
  endtask

  initial begin
    int w;
    int t;
    int vcnt;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_outsel", outsel, 4'h0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_ready_out", ready_out, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;

    send(2'b10, rinst(7'h20, 3'd0), 32'd5, 32'd7, w);
    chk("first_accept", w, 0);
    for (int i = 0; i < 8; i++) send(2'b10, rinst(7'h00, 3'(i)), 32'h8000_00F0, 32'hFFFF_FF24, w);
    for (int i = 0; i < 8; i++) send(2'b10, rinst(7'h00, 3'(i)), $urandom(), $urandom(), w);
    send(2'b01, 32'h0000_0000, 32'hFFFF_FFFF, 32'd1, w);
    send(2'b01, 32'h0000_2000, 32'hFFFF_FFFF, 32'd1, w);
    send(2'b00, 32'h1234_5678, 32'hFFFF_FFF0, 32'd32, w);
    send(2'b10, rinst(7'h20, 3'd5), 32'h8000_0000, 32'h0000_003F, w);
    send(2'b10, rinst(7'h20, 3'd1), 32'd3, 32'd4, w);
    send(2'b10, rinst(7'h10, 3'd0), 32'd3, 32'd4, w);
    wait_drain();

    send(2'b10, rinst(7'h01, 3'd1), 32'h8000_0000, 32'h8000_0000, w);
    for (int i = 0; i < 4; i++) send(2'b10, rinst(7'h01, 3'(i)), $urandom(), $urandom(), w);
    send(2'b10, rinst(7'h01, 3'd2), 32'hFFFF_FFFD, 32'hFFFF_FFFF, w);
    send(2'b10, rinst(7'h01, 3'd4), 32'h8000_0000, 32'hFFFF_FFFF, w);
    send(2'b10, rinst(7'h01, 3'd7), 32'd9, 32'd0, w);
    send(2'b10, rinst(7'h01, 3'd4), 32'd9, 32'd0, w);
    send(2'b10, rinst(7'h01, 3'd6), 32'h8000_0000, 32'hFFFF_FFFF, w);
    for (int i = 4; i < 8; i++) send(2'b10, rinst(7'h01, 3'(i)), 32'hFFFF_FFF9, 32'd2, w);
    for (int i = 4; i < 8; i++) send(2'b10, rinst(7'h01, 3'(i)), $urandom(), $urandom_range(1, 1000), w);
    wait_drain();

    ready_in = 1'b0;
    send(2'b00, 32'h0, 32'd3, 32'd4, w);
    t = 0;
    while (!valid_out && t < 50) begin @(posedge clk); #1; t++; end
    chk("hold_reach_done", valid_out, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", valid_out, 1'b1);
      chk("hold_result", result, 32'd7);
      chk("hold_ready_out", ready_out, 1'b0);
    end
    @(posedge clk); #1 ready_in = 1'b1;
    send(2'b00, 32'h0, 32'd1, 32'd1, w);
    chk("b2b_accept_waits", w, 0);
    wait_drain();

    send(2'b10, rinst(7'h01, 3'd5), 32'd100, 32'd7, w);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", valid_out, 1'b0);
    chk("arst_result", result, 32'h0);
    chk("arst_outsel", outsel, 4'h0);
    chk("arst_illegal", illegal, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    send(2'b11, 32'hFFFF_FFFF, 32'd5, 32'd6, w);
    chk("accept_after_rst", w, 0);
    wait_drain();
    vcnt = 0;
    repeat (50) begin @(negedge clk); if (valid_out) vcnt++; end
    chk("no_valid_after_rst", vcnt, 0);

    wait_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
